// File: rtl/sched_pkg.sv
// Shared encodings for the LabSO process scheduler: slot states, switch FSM
// states and the context-switch event types.
package sched_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_READY   = 2'd1,
    SLOT_RUNNING = 2'd2,
    SLOT_BLOCKED = 2'd3
  } slot_state_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SAVE,
    ST_SELECT,
    ST_RESTORE
  } sched_state_t;

  typedef enum logic [1:0] {
    EV_FINISH,
    EV_IO_TRAP,
    EV_PREEMPT
  } sched_event_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: first set bit of ready after start, wrapping,
// with start itself searched last. Bit 0 (the OS slot) is never picked.
module rr_picker #(
  parameter int unsigned NUM_PROC = 4,
  parameter int unsigned PIDW     = 2
) (
  input  logic [NUM_PROC-1:0] ready,
  input  logic [PIDW-1:0]     start,
  output logic [PIDW-1:0]     pick,
  output logic                found
);

  logic [NUM_PROC-1:0] cand;
  logic [PIDW-1:0]     idx;

  always_comb begin
    cand    = ready;
    cand[0] = 1'b0;
    pick    = '0;
    found   = 1'b0;
    idx     = '0;
    // NUM_PROC is a power of two, so truncating the sum is the modulo wrap
    for (int unsigned i = 1; i <= NUM_PROC; i++) begin
      idx = start + PIDW'(i);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: slot table (state + saved PC) and the
// RUN -> SAVE -> SELECT -> RESTORE context-switch sequencer.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned           NUM_PROC    = 4,
  parameter int unsigned           PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   OS_ENTRY_PC = '0,
  localparam int unsigned          PIDW        = $clog2(NUM_PROC)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                preempt,
  input  logic                io_trap,
  input  logic                proc_finish,
  input  logic [PC_WIDTH-1:0] saved_pc,
  input  logic                io_done,
  input  logic [PIDW-1:0]     io_done_pid,
  input  logic                create_valid,
  input  logic [PIDW-1:0]     create_pid,
  input  logic [PC_WIDTH-1:0] create_pc,
  output logic                create_ack,
  output logic [PIDW-1:0]     current_pid,
  output logic                load_pc_valid,
  output logic [PC_WIDTH-1:0] load_pc,
  output logic                busy
);

  sched_state_t        state, state_next;
  slot_state_t         slot_st [NUM_PROC];
  logic [PC_WIDTH-1:0] slot_pc [NUM_PROC];

  logic [PIDW-1:0]     last_pid;
  logic [PIDW-1:0]     pick, pick_q;
  logic                found;
  logic [NUM_PROC-1:0] ready_vec;

  sched_event_t        ev_q, ev_next;
  logic                ev_latch;
  logic [PC_WIDTH-1:0] ev_pc_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      ready_vec[i] = (slot_st[i] == SLOT_READY);
    end
  end

  rr_picker #(
    .NUM_PROC (NUM_PROC),
    .PIDW     (PIDW)
  ) u_picker (
    .ready (ready_vec),
    .start (last_pid),
    .pick  (pick),
    .found (found)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ev_latch   = 1'b0;
    ev_next    = EV_PREEMPT;
    unique case (state)
      ST_RUN: begin
        if (current_pid != '0) begin
          if (proc_finish) begin
            ev_next  = EV_FINISH;
            ev_latch = 1'b1;
          end else if (io_trap) begin
            ev_next  = EV_IO_TRAP;
            ev_latch = 1'b1;
          end else if (preempt) begin
            ev_next  = EV_PREEMPT;
            ev_latch = 1'b1;
          end
          if (ev_latch) state_next = ST_SAVE;
        end else if (found) begin
          // OS has no context to save, go straight to selection
          state_next = ST_SELECT;
        end
      end
      ST_SAVE:    state_next = ST_SELECT;
      ST_SELECT:  state_next = ST_RESTORE;
      ST_RESTORE: state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
  end

  assign busy = (state != ST_RUN);

  // Create only hits FREE slots, io_done only BLOCKED ones, SAVE only the
  // RUNNING one and RESTORE only the READY pick, so the writes never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PROC; i++) begin
        slot_st[i] <= SLOT_FREE;
        slot_pc[i] <= '0;
      end
      current_pid   <= '0;
      last_pid      <= '0;
      pick_q        <= '0;
      ev_q          <= EV_PREEMPT;
      ev_pc_q       <= '0;
      load_pc       <= '0;
      load_pc_valid <= 1'b0;
      create_ack    <= 1'b0;
    end else begin
      load_pc_valid <= 1'b0;
      create_ack    <= 1'b0;

      if (ev_latch) begin
        ev_q    <= ev_next;
        ev_pc_q <= saved_pc;
      end

      if (create_valid && create_pid != '0 && slot_st[create_pid] == SLOT_FREE) begin
        slot_st[create_pid] <= SLOT_READY;
        slot_pc[create_pid] <= create_pc;
        create_ack          <= 1'b1;
      end

      if (io_done && io_done_pid != '0 && slot_st[io_done_pid] == SLOT_BLOCKED) begin
        slot_st[io_done_pid] <= SLOT_READY;
      end

      unique case (state)
        ST_SAVE: begin
          unique case (ev_q)
            EV_FINISH: slot_st[current_pid] <= SLOT_FREE;
            EV_IO_TRAP: begin
              slot_st[current_pid] <= SLOT_BLOCKED;
              slot_pc[current_pid] <= ev_pc_q;
            end
            default: begin
              slot_st[current_pid] <= SLOT_READY;
              slot_pc[current_pid] <= ev_pc_q;
            end
          endcase
        end
        ST_SELECT: pick_q <= pick;
        ST_RESTORE: begin
          current_pid   <= pick_q;
          load_pc_valid <= 1'b1;
          if (pick_q != '0) begin
            slot_st[pick_q] <= SLOT_RUNNING;
            last_pid        <= pick_q;
            load_pc         <= slot_pc[pick_q];
          end else begin
            load_pc <= OS_ENTRY_PC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed vector table, reset-abort sequence,
// then random operations checked against a slot-table reference model.
module tb_process_scheduler;

  localparam int unsigned NP    = 4;
  localparam int unsigned PIDW  = 2;
  localparam logic [31:0] OS_PC = 32'h0000_0F00;

  localparam int M_FREE = 0, M_READY = 1, M_RUNNING = 2, M_BLOCKED = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            preempt = 1'b0, io_trap = 1'b0, proc_finish = 1'b0;
  logic [31:0]     saved_pc = '0;
  logic            io_done = 1'b0;
  logic [PIDW-1:0] io_done_pid = '0;
  logic            create_valid = 1'b0;
  logic [PIDW-1:0] create_pid = '0;
  logic [31:0]     create_pc = '0;
  logic            create_ack, load_pc_valid, busy;
  logic [PIDW-1:0] current_pid;
  logic [31:0]     load_pc;

  process_scheduler #(
    .NUM_PROC    (NP),
    .PC_WIDTH    (32),
    .OS_ENTRY_PC (OS_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .preempt       (preempt),
    .io_trap       (io_trap),
    .proc_finish   (proc_finish),
    .saved_pc      (saved_pc),
    .io_done       (io_done),
    .io_done_pid   (io_done_pid),
    .create_valid  (create_valid),
    .create_pid    (create_pid),
    .create_pc     (create_pc),
    .create_ack    (create_ack),
    .current_pid   (current_pid),
    .load_pc_valid (load_pc_valid),
    .load_pc       (load_pc),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef enum int {OP_CREATE, OP_IODONE, OP_PRE, OP_IO, OP_FIN, OP_FINPRE} op_t;
  typedef struct {
    int          ack;
    int          pulses;
    int          lat;
    int          cur;
    logic [31:0] lpc;
    int          busy_cnt;
  } obs_t;
  typedef struct {
    op_t         op;
    int          pid;
    logic [31:0] pc;
    obs_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic compare_obs(input string tag, input obs_t g, input obs_t e);
    check({tag, ".ack"},    32'(g.ack),      32'(e.ack));
    check({tag, ".pulses"}, 32'(g.pulses),   32'(e.pulses));
    check({tag, ".lat"},    32'(g.lat),      32'(e.lat));
    check({tag, ".cur"},    32'(g.cur),      32'(e.cur));
    check({tag, ".lpc"},    g.lpc,           e.lpc);
    check({tag, ".busy"},   32'(g.busy_cnt), 32'(e.busy_cnt));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one operation for one cycle, then observe the following 7 samples.
  task automatic do_op(input op_t op, input int pid, input logic [31:0] pc, output obs_t o);
    o = '{default: 0};
    case (op)
      OP_CREATE: begin create_valid = 1'b1; create_pid = PIDW'(pid); create_pc = pc; end
      OP_IODONE: begin io_done = 1'b1; io_done_pid = PIDW'(pid); end
      OP_PRE:    begin preempt = 1'b1; saved_pc = pc; end
      OP_IO:     begin io_trap = 1'b1; saved_pc = pc; end
      OP_FIN:    begin proc_finish = 1'b1; saved_pc = pc; end
      default:   begin proc_finish = 1'b1; preempt = 1'b1; saved_pc = pc; end
    endcase
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) begin
        o.ack = int'(create_ack);
        create_valid = 1'b0; io_done = 1'b0;
        preempt = 1'b0; io_trap = 1'b0; proc_finish = 1'b0;
      end else if (create_ack) begin
        o.ack += 2;
      end
      if (busy) o.busy_cnt++;
      if (load_pc_valid) begin
        o.pulses++;
        if (o.lat == 0) o.lat = t;
      end
    end
    o.cur = int'(current_pid);
    o.lpc = load_pc;
  endtask

  // Reference model: slot table at transaction level.
  int          ms [NP];
  logic [31:0] mpc [NP];
  int          m_cur, m_last;
  logic [31:0] m_lpc;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin ms[i] = M_FREE; mpc[i] = '0; end
    m_cur = 0; m_last = 0; m_lpc = '0;
  endtask

  task automatic model_switch(inout obs_t e);
    int p = 0;
    for (int k = 1; k <= NP; k++) begin
      int idx = (m_last + k) % NP;
      if (p == 0 && idx != 0 && ms[idx] == M_READY) p = idx;
    end
    if (p != 0) begin
      ms[p] = M_RUNNING; m_last = p; m_lpc = mpc[p];
    end else begin
      m_lpc = OS_PC;
    end
    m_cur = p;
    e.pulses = 1;
    e.lat = 4;
  endtask

  task automatic model_op(input op_t op, input int pid, input logic [31:0] pc, output obs_t e);
    bit any_ready = 0;
    e = '{default: 0};
    case (op)
      OP_CREATE: if (pid != 0 && ms[pid] == M_FREE) begin
        ms[pid] = M_READY; mpc[pid] = pc; e.ack = 1;
      end
      OP_IODONE: if (pid != 0 && ms[pid] == M_BLOCKED) ms[pid] = M_READY;
      default: if (m_cur != 0) begin
        if (op == OP_FIN || op == OP_FINPRE) ms[m_cur] = M_FREE;
        else if (op == OP_IO) begin ms[m_cur] = M_BLOCKED; mpc[m_cur] = pc; end
        else begin ms[m_cur] = M_READY; mpc[m_cur] = pc; end
        e.busy_cnt = 3;
        model_switch(e);
      end
    endcase
    if (op == OP_CREATE || op == OP_IODONE) begin
      for (int i = 1; i < NP; i++) if (ms[i] == M_READY) any_ready = 1;
      if (m_cur == 0 && any_ready) begin
        e.busy_cnt = 2;
        model_switch(e);
      end
    end
    e.cur = m_cur;
    e.lpc = m_lpc;
  endtask

  function automatic vec_t mk(op_t op, int pid, logic [31:0] pc, int ack, int pul,
                              int cur, logic [31:0] lpc, int bsy);
    vec_t v;
    v.op = op; v.pid = pid; v.pc = pc;
    v.exp.ack = ack; v.exp.pulses = pul; v.exp.lat = pul ? 4 : 0;
    v.exp.cur = cur; v.exp.lpc = lpc; v.exp.busy_cnt = bsy;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t vq[$];
  obs_t got, exp;

  initial begin
    // op, pid, pc, ack, pulses, cur, load_pc, busy cycles
    vq.push_back(mk(OP_CREATE, 1, 32'h100, 1, 1, 1, 32'h100, 2));
    vq.push_back(mk(OP_CREATE, 2, 32'h200, 1, 0, 1, 32'h100, 0));
    vq.push_back(mk(OP_CREATE, 3, 32'h300, 1, 0, 1, 32'h100, 0));
    vq.push_back(mk(OP_PRE,    0, 32'h105, 0, 1, 2, 32'h200, 3));
    vq.push_back(mk(OP_PRE,    0, 32'h205, 0, 1, 3, 32'h300, 3));
    vq.push_back(mk(OP_PRE,    0, 32'h305, 0, 1, 1, 32'h105, 3));
    vq.push_back(mk(OP_FIN,    0, 32'h0,   0, 1, 2, 32'h205, 3));
    vq.push_back(mk(OP_FIN,    0, 32'h0,   0, 1, 3, 32'h305, 3));
    vq.push_back(mk(OP_FIN,    0, 32'h0,   0, 1, 0, OS_PC,   3));
    vq.push_back(mk(OP_PRE,    0, 32'h123, 0, 0, 0, OS_PC,   0));
    vq.push_back(mk(OP_CREATE, 1, 32'h40,  1, 1, 1, 32'h40,  2));
    vq.push_back(mk(OP_IO,     0, 32'h20,  0, 1, 0, OS_PC,   3));
    vq.push_back(mk(OP_IODONE, 1, 32'h0,   0, 1, 1, 32'h20,  2));
    vq.push_back(mk(OP_FINPRE, 0, 32'h999, 0, 1, 0, OS_PC,   3));
    vq.push_back(mk(OP_CREATE, 1, 32'h500, 1, 1, 1, 32'h500, 2));
    vq.push_back(mk(OP_CREATE, 0, 32'h700, 0, 0, 1, 32'h500, 0));
    vq.push_back(mk(OP_CREATE, 1, 32'h700, 0, 0, 1, 32'h500, 0));
    vq.push_back(mk(OP_CREATE, 2, 32'h600, 1, 0, 1, 32'h500, 0));
    vq.push_back(mk(OP_IODONE, 2, 32'h0,   0, 0, 1, 32'h500, 0));
    vq.push_back(mk(OP_CREATE, 2, 32'h777, 0, 0, 1, 32'h500, 0));
    vq.push_back(mk(OP_PRE,    0, 32'h510, 0, 1, 2, 32'h600, 3));
    vq.push_back(mk(OP_IODONE, 0, 32'h0,   0, 0, 2, 32'h600, 0));
    vq.push_back(mk(OP_IO,     0, 32'h610, 0, 1, 1, 32'h510, 3));
    vq.push_back(mk(OP_IODONE, 1, 32'h0,   0, 0, 1, 32'h510, 0));
    vq.push_back(mk(OP_IODONE, 2, 32'h0,   0, 0, 1, 32'h510, 0));
    vq.push_back(mk(OP_PRE,    0, 32'h520, 0, 1, 2, 32'h610, 3));

    // Reset values
    tick();
    tick();
    check("rst.current_pid",   32'(current_pid),   32'd0);
    check("rst.load_pc",       load_pc,            32'd0);
    check("rst.load_pc_valid", 32'(load_pc_valid), 32'd0);
    check("rst.busy",          32'(busy),          32'd0);
    check("rst.create_ack",    32'(create_ack),    32'd0);
    reset = 1'b0;

    foreach (vq[i]) begin
      do_op(vq[i].op, vq[i].pid, vq[i].pc, got);
      compare_obs($sformatf("vec%0d", i), got, vq[i].exp);
    end

    // Reset asserted while the switch sits in SELECT aborts it
    do_reset();
    create_valid = 1'b1; create_pid = 2'd1; create_pc = 32'hABC;
    tick();
    check("abort.ack", 32'(create_ack), 32'd1);
    create_valid = 1'b0;
    tick();
    check("abort.busy_select", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = '{default: 0};
    for (int t = 0; t < 6; t++) begin
      tick();
      if (load_pc_valid) got.pulses++;
      if (busy) got.busy_cnt++;
    end
    check("abort.pulses", 32'(got.pulses),   32'd0);
    check("abort.busy",   32'(got.busy_cnt), 32'd0);
    check("abort.cur",    32'(current_pid),  32'd0);
    check("abort.lpc",    load_pc,           32'd0);
    do_op(OP_CREATE, 1, 32'hDEF, got);
    compare_obs("abort.recreate", got, mk(OP_CREATE, 1, 32'hDEF, 1, 1, 1, 32'hDEF, 2).exp);

    // Random operations against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 300; n++) begin
      int          r   = int'($urandom_range(0, 9));
      int          pid = int'($urandom_range(0, NP - 1));
      logic [31:0] pc  = $urandom;
      op_t         op;
      if (r <= 2)      op = OP_CREATE;
      else if (r <= 4) op = OP_IODONE;
      else if (r <= 6) op = OP_PRE;
      else if (r == 7) op = OP_IO;
      else if (r == 8) op = OP_FIN;
      else             op = OP_FINPRE;
      model_op(op, pid, pc, exp);
      do_op(op, pid, pc, got);
      compare_obs($sformatf("rnd%0d", n), got, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
